// File: rtl/alu_seq_if.sv
// Transaction bus for alu_seq: request side (opcode/operands with valid/ready)
// and completion side (registered result, status register, illegal pulse).
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       opcode;
    logic [WIDTH-1:0] rdataA;
    logic [WIDTH-1:0] rdataB;
    logic             out_valid;
    logic [WIDTH-1:0] result;
    logic [4:0]       psrOut;
    logic             illegal;

    // Producer of transactions and consumer of results.
    modport master (
        output in_valid, opcode, rdataA, rdataB,
        input  in_ready, out_valid, result, psrOut, illegal
    );

    // The ALU itself.
    modport slave (
        input  in_valid, opcode, rdataA, rdataB,
        output in_ready, out_valid, result, psrOut, illegal
    );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU: single-cycle logic/arithmetic ops plus an optional
// iterative shift-add unsigned multiply taking WIDTH cycles. Produces a
// registered result and a 5-bit status register {N, Z, F, L, C}.
module alu_seq #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic       clock,
    input  logic       reset,
    alu_seq_if.slave   bus
);
    localparam logic [7:0] OP_AND  = 8'h01;
    localparam logic [7:0] OP_OR   = 8'h02;
    localparam logic [7:0] OP_XOR  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h05;
    localparam logic [7:0] OP_ADDU = 8'h06;
    localparam logic [7:0] OP_SUB  = 8'h09;
    localparam logic [7:0] OP_CMP  = 8'h0B;
    localparam logic [7:0] OP_MUL  = 8'h0D;

    // Status register bit positions.
    localparam int PSR_C = 0;
    localparam int PSR_L = 1;
    localparam int PSR_F = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic {ST_IDLE, ST_MUL} state_t;

    state_t             state, state_next;
    logic               in_ready;
    logic               accept;
    logic               is_mul;
    logic               last_iter;

    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc, acc_next, addend;
    logic [CW-1:0]      cnt;

    logic [WIDTH-1:0]   result_q;
    logic [4:0]         psr_q;
    logic               out_valid_q;
    logic               illegal_q;

    logic [WIDTH-1:0]   alu_res;
    logic [4:0]         alu_psr;
    logic               alu_illegal;
    logic [WIDTH:0]     sum_ext, diff_ext;

    assign accept    = bus.in_valid && in_ready;
    assign is_mul    = MUL_EN && (bus.opcode == OP_MUL);
    assign last_iter = (cnt == CW'(WIDTH - 1));

    // State register.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking (<=) so every register
        // samples pre-edge values regardless of statement order.
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // Next-state logic: leave IDLE on an accepted MUL, return after WIDTH iterations.
    always_comb begin
        // NOTE: default assignment first so no path leaves the output
        // unassigned, which would infer a latch.
        state_next = state;
        case (state)
            ST_IDLE: if (accept && is_mul) state_next = ST_MUL;
            ST_MUL:  if (last_iter)        state_next = ST_IDLE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: only IDLE accepts new work.
    always_comb begin
        in_ready = (state == ST_IDLE);
    end

    // Single-cycle ALU; unaffected status bits and CMP's result pass through unchanged.
    always_comb begin
        sum_ext     = {1'b0, bus.rdataA} + {1'b0, bus.rdataB};
        diff_ext    = {1'b0, bus.rdataA} - {1'b0, bus.rdataB};
        alu_res     = result_q;
        alu_psr     = psr_q;
        alu_illegal = 1'b0;
        case (bus.opcode)
            OP_AND, OP_OR, OP_XOR: begin
                if (bus.opcode == OP_AND)     alu_res = bus.rdataA & bus.rdataB;
                else if (bus.opcode == OP_OR) alu_res = bus.rdataA | bus.rdataB;
                else                          alu_res = bus.rdataA ^ bus.rdataB;
                alu_psr[PSR_Z] = (alu_res == '0);
                alu_psr[PSR_N] = alu_res[MSB];
            end
            OP_ADD: begin
                alu_res        = sum_ext[MSB:0];
                alu_psr[PSR_Z] = (alu_res == '0);
                alu_psr[PSR_N] = alu_res[MSB];
                alu_psr[PSR_F] = (bus.rdataA[MSB] == bus.rdataB[MSB]) &&
                                 (alu_res[MSB] != bus.rdataA[MSB]);
            end
            OP_ADDU: begin
                alu_res        = sum_ext[MSB:0];
                alu_psr[PSR_C] = sum_ext[WIDTH];
                alu_psr[PSR_Z] = (alu_res == '0);
            end
            OP_SUB: begin
                alu_res        = diff_ext[MSB:0];
                alu_psr[PSR_C] = diff_ext[WIDTH];
                alu_psr[PSR_Z] = (alu_res == '0);
                alu_psr[PSR_N] = alu_res[MSB];
                alu_psr[PSR_F] = (bus.rdataA[MSB] != bus.rdataB[MSB]) &&
                                 (alu_res[MSB] != bus.rdataA[MSB]);
            end
            OP_CMP: begin
                alu_psr[PSR_Z] = (bus.rdataA == bus.rdataB);
                alu_psr[PSR_L] = (bus.rdataA < bus.rdataB);
                alu_psr[PSR_N] = ($signed(bus.rdataA) < $signed(bus.rdataB));
            end
            default: begin
                alu_res     = '0;
                alu_illegal = 1'b1;
            end
        endcase
    end

    // Shift-add step: add A<<cnt into the accumulator when B[cnt] is set.
    always_comb begin
        addend   = b_q[cnt] ? ({{WIDTH{1'b0}}, a_q} << cnt) : '0;
        acc_next = acc + addend;
    end

    // Datapath registers: operand capture, multiply iteration, result/status update.
    always_ff @(posedge clock) begin
        // NOTE: the multiplier registers are cleared too, so an aborted
        // multiply leaves no residue for the next one.
        if (reset) begin
            a_q         <= '0;
            b_q         <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_q    <= '0;
            psr_q       <= '0;
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            if (state == ST_IDLE) begin
                if (accept && is_mul) begin
                    a_q <= bus.rdataA;
                    b_q <= bus.rdataB;
                    acc <= '0;
                    cnt <= '0;
                end else if (accept) begin
                    result_q    <= alu_res;
                    psr_q       <= alu_psr;
                    out_valid_q <= 1'b1;
                    illegal_q   <= alu_illegal;
                end
            end else begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
                if (last_iter) begin
                    result_q       <= acc_next[MSB:0];
                    psr_q[PSR_C]   <= (acc_next[2*WIDTH-1:WIDTH] != '0);
                    psr_q[PSR_Z]   <= (acc_next[MSB:0] == '0);
                    out_valid_q    <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.psrOut    = psr_q;
    assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq at WIDTH=8, compared against a
// behavioural model written with plain integer arithmetic. A second instance
// with MUL_EN=0 covers the multiply-disabled configuration.
module tb_alu_seq;
    localparam int W = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: last result and status register.
    int         m_res = 0;
    logic [4:0] m_psr = '0;

    alu_seq_if #(.WIDTH(W)) bif ();
    alu_seq_if #(.WIDTH(W)) nif ();

    alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif)
    );

    alu_seq #(.WIDTH(W), .MUL_EN(1'b0)) u_dut_nomul (
        .clock (clock),
        .reset (reset),
        .bus   (nif)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: apply one operation to the model using integer arithmetic.
    task automatic model_step(input logic [7:0] op, input int a, input int b, output int ill);
        int sa, sb, r, p;
        sa  = (a >= 128) ? a - 256 : a;
        sb  = (b >= 128) ? b - 256 : b;
        ill = 0;
        case (op)
            8'h01, 8'h02, 8'h03: begin
                m_res    = (op == 8'h01) ? (a & b) : (op == 8'h02) ? (a | b) : (a ^ b);
                m_psr[3] = (m_res == 0);
                m_psr[4] = (m_res >= 128);
            end
            8'h05: begin
                r        = sa + sb;
                m_res    = (a + b) & 255;
                m_psr[2] = (r > 127) || (r < -128);
                m_psr[3] = (m_res == 0);
                m_psr[4] = (m_res >= 128);
            end
            8'h06: begin
                m_res    = (a + b) & 255;
                m_psr[0] = (a + b) > 255;
                m_psr[3] = (m_res == 0);
            end
            8'h09: begin
                r        = sa - sb;
                m_res    = (a - b) & 255;
                m_psr[0] = (a < b);
                m_psr[2] = (r > 127) || (r < -128);
                m_psr[3] = (m_res == 0);
                m_psr[4] = (m_res >= 128);
            end
            8'h0B: begin
                m_psr[3] = (a == b);
                m_psr[1] = (a < b);
                m_psr[4] = (sa < sb);
            end
            8'h0D: begin
                p        = a * b;
                m_res    = p & 255;
                m_psr[0] = (p > 255);
                m_psr[3] = (m_res == 0);
            end
            default: begin
                m_res = 0;
                ill   = 1;
            end
        endcase
    endtask

    task automatic drive(input logic [7:0] op, input int a, input int b);
        @(negedge clock);
        bif.in_valid = 1'b1;
        bif.opcode   = op;
        bif.rdataA   = W'(a);
        bif.rdataB   = W'(b);
        @(posedge clock);
        #1;
        bif.in_valid = 1'b0;
    endtask

    task automatic single_op(input logic [7:0] op, input int a, input int b);
        int ill;
        drive(op, a, b);
        model_step(op, a, b, ill);
        check("out_valid", int'(bif.out_valid), 1);
        check("illegal", int'(bif.illegal), ill);
        check("result", int'(bif.result), m_res);
        check("psr", int'(bif.psrOut), int'(m_psr));
        check("in_ready", int'(bif.in_ready), 1);
    endtask

    // Multiply with optional in_valid pulses (random garbage) while busy.
    task automatic mul_op(input int a, input int b, input bit pulse);
        int ill;
        int n;
        drive(8'h0D, a, b);
        check("mul_busy_ready", int'(bif.in_ready), 0);
        check("mul_busy_valid", int'(bif.out_valid), 0);
        n = 0;
        while (n < 3 * W) begin
            @(negedge clock);
            if (pulse && (n % 2 == 0)) begin
                bif.in_valid = 1'b1;
                bif.opcode   = 8'($urandom);
                bif.rdataA   = W'($urandom);
                bif.rdataB   = W'($urandom);
            end
            @(posedge clock);
            #1;
            bif.in_valid = 1'b0;
            n++;
            if (bif.out_valid) break;
        end
        check("mul_latency", n, W);
        model_step(8'h0D, a, b, ill);
        check("mul_in_ready", int'(bif.in_ready), 1);
        check("mul_illegal", int'(bif.illegal), 0);
        check("mul_result", int'(bif.result), m_res);
        check("mul_psr", int'(bif.psrOut), int'(m_psr));
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        @(negedge clock);
        reset = 1'b0;
        m_res = 0;
        m_psr = '0;
    endtask

    task automatic nomul_op(input logic [7:0] op, input int a, input int b);
        @(negedge clock);
        nif.in_valid = 1'b1;
        nif.opcode   = op;
        nif.rdataA   = W'(a);
        nif.rdataB   = W'(b);
        @(posedge clock);
        #1;
        nif.in_valid = 1'b0;
    endtask

    function automatic int pick_operand();
        int sel;
        sel = $urandom_range(0, 7);
        case (sel)
            0: return 0;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return int'($urandom_range(0, 255));
        endcase
    endfunction

    initial begin
        logic [7:0] ops [8] = '{8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0B, 8'h0D};
        logic [7:0] op;
        bit         saw_valid;

        bif.in_valid = 1'b0;
        bif.opcode   = '0;
        bif.rdataA   = '0;
        bif.rdataB   = '0;
        nif.in_valid = 1'b0;
        nif.opcode   = '0;
        nif.rdataA   = '0;
        nif.rdataB   = '0;

        repeat (2) @(posedge clock);
        #1;
        check("rst_result", int'(bif.result), 0);
        check("rst_psr", int'(bif.psrOut), 0);
        check("rst_out_valid", int'(bif.out_valid), 0);
        check("rst_illegal", int'(bif.illegal), 0);
        check("rst_in_ready", int'(bif.in_ready), 1);
        @(negedge clock);
        reset = 1'b0;

        // ADD overflow into the sign bit.
        single_op(8'h05, 8'h7F, 8'h01);
        check("add_res_const", int'(bif.result), 8'h80);
        check("add_psr_const", int'(bif.psrOut), 5'b10100);

        // ADDU carry, then AND to zero keeps C.
        apply_reset();
        single_op(8'h06, 8'hFF, 8'h02);
        check("addu_psr_const", int'(bif.psrOut), 5'b00001);
        single_op(8'h01, 8'hF0, 8'h0F);
        check("and_psr_const", int'(bif.psrOut), 5'b01001);

        // CMP leaves the result untouched.
        single_op(8'h02, 8'h11, 8'h00);
        single_op(8'h0B, 8'h05, 8'h80);
        check("cmp_res_const", int'(bif.result), 8'h11);

        // Idle cycle: no completion pulse.
        @(posedge clock);
        #1;
        check("idle_out_valid", int'(bif.out_valid), 0);

        // Multiply with ignored requests while busy.
        mul_op(8'h10, 8'h11, 1'b1);
        check("mul_res_const", int'(bif.result), 8'h10);

        // Reset during multiply: aborted with no completion.
        drive(8'h0D, 8'h03, 8'h04);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("abort_out_valid", int'(bif.out_valid), 0);
        check("abort_result", int'(bif.result), 0);
        check("abort_psr", int'(bif.psrOut), 0);
        check("abort_in_ready", int'(bif.in_ready), 1);
        @(negedge clock);
        reset = 1'b0;
        m_res = 0;
        m_psr = '0;
        saw_valid = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (bif.out_valid) saw_valid = 1'b1;
        end
        check("abort_no_pulse", int'(saw_valid), 0);

        // Undefined opcode.
        single_op(8'h06, 8'hFF, 8'h02);
        single_op(8'h44, 8'h12, 8'h34);
        check("ill_psr_const", int'(bif.psrOut), 5'b00001);

        // MUL disabled: treated as illegal, status held.
        nomul_op(8'h06, 8'hFF, 8'h02);
        check("nm_addu_psr", int'(nif.psrOut), 5'b00001);
        nomul_op(8'h0D, 8'h03, 8'h04);
        check("nm_out_valid", int'(nif.out_valid), 1);
        check("nm_illegal", int'(nif.illegal), 1);
        check("nm_result", int'(nif.result), 0);
        check("nm_psr", int'(nif.psrOut), 5'b00001);
        check("nm_in_ready", int'(nif.in_ready), 1);

        // Randomized back-to-back traffic with occasional gaps.
        for (int i = 0; i < 200; i++) begin
            int sel;
            int a;
            int b;
            sel = $urandom_range(0, 8);
            op  = (sel == 8) ? 8'($urandom_range(8'h10, 8'hFF)) : ops[sel];
            a   = pick_operand();
            b   = pick_operand();
            if (op == 8'h0D) mul_op(a, b, $urandom_range(0, 1) == 1);
            else             single_op(op, a, b);
            if ($urandom_range(0, 5) == 0) begin
                @(posedge clock);
                #1;
                check("gap_out_valid", int'(bif.out_valid), 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, handshaked successor to the datapath ALU. It takes one 8-bit opcode and two WIDTH-bit operands per transaction. It returns a registered WIDTH-bit result and a 5-bit processor status register (PSR). Single-cycle logic/arithmetic ops complete in 1 cycle. An iterative shift-add unsigned multiply completes in WIDTH cycles. PSR bits not affected by an op hold their previous value.

Parameters:
WIDTH, 16, operand/result width in bits; legal range 4..32.
MUL_EN, 1, 1 = MUL opcode implemented; 0 = MUL is treated as illegal.

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous reset, active-high
in_valid  input  1  opcode/operands are valid this cycle
in_ready  output  1  block can accept a transaction this cycle
opcode  input  8  operation select
rdataA  input  WIDTH  operand A
rdataB  input  WIDTH  operand B
out_valid  output  1  one-cycle pulse: result/psrOut were updated at the preceding edge
result  output  WIDTH  registered result; holds between completions
psrOut  output  5  [0] C carry/borrow, [1] L unsigned-less, [2] F signed overflow, [3] Z zero, [4] N negative/signed-less
illegal  output  1  one-cycle pulse, coincident with out_valid, for an undefined opcode

Behaviour:
- Reset (reset=1 at an edge): result=0, psrOut=0, out_valid=0, illegal=0, FSM->IDLE, in_ready=1, multiplier state cleared. Reset dominates any in-flight op, including a MUL mid-iteration; no completion pulse follows.
- Accept: a transaction is accepted at an edge where in_valid && in_ready. When in_ready=0, inputs are ignored.
- FSM states: IDLE and MUL.
  - IDLE: in_ready=1. An accepted non-MUL op completes at the same edge: result/psrOut update and out_valid=1 for the following cycle. An accepted MUL moves the FSM to MUL.
  - MUL: in_ready=0. A counter runs WIDTH iterations; each iteration conditionally adds A<<i into a 2*WIDTH-bit accumulator. At the WIDTH-th edge after acceptance, the FSM returns to IDLE, result/psrOut update, and out_valid pulses. in_ready rises in the same cycle as out_valid.
- Back-to-back: in IDLE, one single-cycle op per clock is sustained. out_valid stays high continuously.
- There is no output backpressure. The consumer must capture on out_valid.
- Opcodes, all arithmetic modulo 2^WIDTH. "Held" means the bit keeps its value from before the op:
  - 0x01 AND, 0x02 OR, 0x03 XOR: result=op; Z=(result==0); N=result[MSB]; C, L, F held.
  - 0x05 ADD (signed): result=A+B; Z, N from result; F=(A[MSB]==B[MSB]) && (result[MSB]!=A[MSB]); C, L held.
  - 0x06 ADDU: result=A+B; C=carry out of bit WIDTH-1; Z from result; L, F, N held.
  - 0x09 SUB: result=A-B; C=borrow (A<B unsigned); F=(A[MSB]!=B[MSB]) && (result[MSB]!=A[MSB]); Z, N from result; L held.
  - 0x0B CMP: result held; Z=(A==B); L=(A<B unsigned); N=(A<B signed); C, F held.
  - 0x0D MUL (MUL_EN=1): result=low WIDTH bits of A*B unsigned; C=(high WIDTH bits != 0); Z from result; L, F, N held.
  - Any other opcode: completes as a single-cycle op; result=0; psrOut held; illegal=1 with out_valid.
- Operands are captured at acceptance. Input changes during MUL have no effect.

Test Plan:
(All at WIDTH=8.)
- Reset, then ADD A=0x7F B=0x01 -> one cycle later out_valid=1, result=0x80, psrOut=5'b10100 (N=1, F=1).
- ADDU A=0xFF B=0x02 after reset -> result=0x01, C=1, Z=0; then AND A=0xF0 B=0x0F -> result=0x00, Z=1, C still 1.
- CMP A=0x05 B=0x80 following a result of 0x11 -> result stays 0x11; Z=0, L=1, N=0 (signed 5 > -128).
- MUL A=0x10 B=0x11 -> in_ready low for 8 cycles; in_valid pulses issued meanwhile are ignored; result=0x10, C=1; in_ready and out_valid both high exactly 8 cycles after acceptance.
- MUL A=0x03 B=0x04, then reset=1 at the 4th busy edge -> no out_valid; result=0, psrOut=0, in_ready=1 next cycle.
- Opcode 0x44, and MUL with MUL_EN=0 -> out_valid=1, illegal=1, result=0, psrOut unchanged.
